alu_decoder_ext: RTL and testbench
==================================

# alu_decoder_ext

Extended ALU decoder for the RV32IM core, placed between the main decoder and the execute stage. It decodes the full RV32I integer ALU operation set into a 4-bit `ALUControl`. It also detects M-extension instructions and runs them on an internal multi-cycle multiply/divide sequencer. While the sequencer is busy it holds the pipeline with `stall`, then presents the result for one cycle.

## Interface
- `OP_WIDTH`, 7, opcode width
- `FUNCT3_WIDTH`, 3, funct3 width
- `ALU_OP_WIDTH`, 2, ALUOp width from main decoder
- `ALU_CTRL_WIDTH`, 4, ALUControl width
- `DATA_WIDTH`, 32, operand/result width (even, ≥ 8)
- `MUL_CYCLES`, 2, busy cycles for multiply ops (≥ 1)

Ports:
- `clk`  in  1  clock; single clock domain, rising edge
- `rst`  in  1  synchronous, active-high reset
- `valid`  in  1  instruction present in execute stage
- `flush`  in  1  abort current instruction
- `op`  in  OP_WIDTH  opcode
- `funct3`  in  FUNCT3_WIDTH  funct3
- `funct7_5`  in  1  instr[30]
- `funct7_0`  in  1  instr[25]; M-extension marker
- `ALUOp`  in  ALU_OP_WIDTH  00 add, 01 branch, 10 R/I-type, 11 pass-B (lui)
- `srcA`, `srcB`  in  DATA_WIDTH  operands, sampled at muldiv start
- `ALUControl`  out  ALU_CTRL_WIDTH  combinational ALU op
- `stall`  out  1  hold IF/ID/EX
- `md_valid`  out  1  `md_result` valid this cycle
- `md_result`  out  DATA_WIDTH  multiply/divide result

## Operation
ALUControl encoding: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt, 0110 sltu, 0111 sll, 1000 srl, 1001 sra, 1010 pass-B.

Decode rules:
- ALUOp 00 → add. ALUOp 01 → sub. ALUOp 11 → pass-B. ALUOp illegal or default → add.
- ALUOp 10 by funct3:
  - 000 → sub if {op[5],funct7_5}=11, else add.
  - 001 → sll.
  - 010 → slt.
  - 011 → sltu.
  - 100 → xor.
  - 101 → sra if funct7_5, else srl (R and I type).
  - 110 → or.
  - 111 → and.
- M-op ≡ ALUOp=10 & op[5] & funct7_0. For an M-op, ALUControl = add.

M-op funct3 mapping:
- 000 mul, 001 mulh, 010 mulhsu, 011 mulhu.
- 100 div, 101 divu, 110 rem, 111 remu.

FSM states: IDLE, MUL, DIV, DONE.
- IDLE: when `valid` & M-op & !`flush`:
  - Latch operands and funct3.
  - Multiply → MUL with counter = MUL_CYCLES.
  - Divide by zero or signed overflow (most-negative / −1) → DONE directly, with the special result precomputed.
  - Other divides → DIV with counter = DATA_WIDTH.
- MUL / DIV: decrement the counter each cycle; at 1 → DONE.
  - DIV is a radix-2 restoring iteration on magnitudes; signs are fixed in DONE.
  - mulh/mulhsu/mulhu return the upper DATA_WIDTH bits of the 2·DATA_WIDTH-bit product; mul returns the lower DATA_WIDTH bits.
- DONE: `md_valid`=1 and `md_result` is stable. Unconditionally → IDLE next cycle. An M-op still present on the inputs in DONE must not restart the sequencer.
- Division special results (RISC-V defined):
  - x/0: quotient all-ones; remainder = dividend.
  - Overflow: quotient = most-negative; remainder = 0.
- `flush` in any state → IDLE next cycle, no `md_valid` pulse. `flush` has priority over start.

## Timing
- `stall` = (IDLE & `valid` & M-op & !`flush`) | MUL | DIV. `stall` is 0 in DONE and while `rst` is high.
- ALUControl has zero latency (combinational).
- Cycle t: M-op arrives in IDLE, `stall`=1.
- Multiply: `stall` high for MUL_CYCLES+1 cycles; DONE at t+MUL_CYCLES+1.
- Normal divide: `stall` high for DATA_WIDTH+1 cycles; DONE at t+DATA_WIDTH+1.
- Special divide: `stall` high for 1 cycle; DONE at t+1.
- Back-to-back M-ops: the next one may start in the cycle after DONE.
- Reset values:
  - state = IDLE, counter = 0.
  - `md_valid` = 0, `md_result` = 0, `stall` = 0.
  - Reset mid-operation discards the operation.
- `md_result` holds its last value outside DONE.

## Test plan
- ALU decode sweep:
  - ALUOp=10, op[5]=1, funct7_5=1, funct3=000 → ALUControl=0001.
  - op[5]=0, funct7_5=1, funct3=000 → 0000.
  - funct3=101, funct7_5=1 → 1001.
  - funct3=111 → 0010.
  - ALUOp=11 → 1010.
- mul: srcA=0xFFFFFFFF, srcB=2, funct3=000 → `stall` 3 cycles, then `md_valid`=1 with 0xFFFFFFFE.
- mulh: srcA=0x80000000, srcB=0x80000000, funct3=001 → result 0x40000000.
- div: srcA=−7, srcB=2 → after 33 stall cycles, quotient 0xFFFFFFFD. Same operands with rem → 0xFFFFFFFF.
- Special divides:
  - divu by 0 with srcA=5 → 1 stall cycle, result 0xFFFFFFFF.
  - rem with srcA=0x80000000, srcB=−1 → result 0.
- `flush` asserted at cycle 10 of a div → IDLE next cycle, `stall`=0, no `md_valid`. Then `rst` pulse mid-mul → all outputs 0.

Source files
------------

// File: rtl/alu_decoder_ext.sv
// RV32IM ALU decoder: combinational ALUControl for RV32I ops plus a multi-cycle
// multiply/divide sequencer for M-extension instructions.
module alu_decoder_ext #(
  parameter int OP_WIDTH       = 7,
  parameter int FUNCT3_WIDTH   = 3,
  parameter int ALU_OP_WIDTH   = 2,
  parameter int ALU_CTRL_WIDTH = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int MUL_CYCLES     = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      valid,
  input  logic                      flush,
  input  logic [OP_WIDTH-1:0]       op,
  input  logic [FUNCT3_WIDTH-1:0]   funct3,
  input  logic                      funct7_5,
  input  logic                      funct7_0,
  input  logic [ALU_OP_WIDTH-1:0]   ALUOp,
  input  logic [DATA_WIDTH-1:0]     srcA,
  input  logic [DATA_WIDTH-1:0]     srcB,
  output logic [ALU_CTRL_WIDTH-1:0] ALUControl,
  output logic                      stall,
  output logic                      md_valid,
  output logic [DATA_WIDTH-1:0]     md_result
);
  localparam int W       = DATA_WIDTH;
  localparam int CNT_MAX = (DATA_WIDTH > MUL_CYCLES) ? DATA_WIDTH : MUL_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;
  typedef enum logic [3:0] {
    ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3,
    ALU_XOR = 4'd4, ALU_SLT = 4'd5, ALU_SLTU = 4'd6, ALU_SLL = 4'd7,
    ALU_SRL = 4'd8, ALU_SRA = 4'd9, ALU_PASSB = 4'd10
  } alu_ctrl_e;

  state_e           state, state_nxt;
  alu_ctrl_e        alu_ctrl;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       f3_q;
  logic [W-1:0]     a_q, b_q, rem_q, quo_q, bmag_q;
  logic             q_neg, r_neg;

  logic m_op, start, sgn_div, a_neg, b_neg, div_special;
  logic [W-1:0] a_mag, b_mag, special_res;
  logic unused_op;

  assign unused_op   = ^{op[OP_WIDTH-1:6], op[4:0]};
  assign m_op        = (ALUOp == ALU_OP_WIDTH'(2)) && op[5] && funct7_0;
  assign start       = valid && m_op && !flush;
  assign sgn_div     = !funct3[0];
  assign a_neg       = sgn_div && srcA[W-1];
  assign b_neg       = sgn_div && srcB[W-1];
  assign a_mag       = a_neg ? -srcA : srcA;
  assign b_mag       = b_neg ? -srcB : srcB;
  assign div_special = (srcB == '0) || (sgn_div && srcA == MOST_NEG && srcB == '1);
  assign special_res = (srcB == '0) ? (funct3[1] ? srcA : '1)
                                    : (funct3[1] ? '0 : MOST_NEG);

  // Operands sign/zero-extended to 2W+2 bits so one unsigned multiply covers all four variants.
  logic [2*W+1:0] mul_a, mul_b, prod;
  logic [W-1:0]   mul_res;
  assign mul_a   = {{(W+2){(f3_q != 2'b11) && a_q[W-1]}}, a_q};
  assign mul_b   = {{(W+2){(f3_q == 2'b01) && b_q[W-1]}}, b_q};
  assign prod    = mul_a * mul_b;
  assign mul_res = (f3_q == 2'b00) ? prod[W-1:0] : prod[2*W-1:W];

  // Restoring divide step on magnitudes; signs are applied to the final step's output.
  logic [W:0]   trial, diff;
  logic         q_bit;
  logic [W-1:0] rem_nxt, quo_nxt, div_res;
  assign trial   = {rem_q, quo_q[W-1]};
  assign diff    = trial - {1'b0, bmag_q};
  assign q_bit   = !diff[W];
  assign rem_nxt = q_bit ? diff[W-1:0] : trial[W-1:0];
  assign quo_nxt = {quo_q[W-2:0], q_bit};
  assign div_res = f3_q[1] ? (r_neg ? -rem_nxt : rem_nxt)
                           : (q_neg ? -quo_nxt : quo_nxt);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) state_nxt = IDLE;
    else begin
      case (state)
        IDLE: if (start) state_nxt = !funct3[2] ? MUL : (div_special ? DONE : DIV);
        MUL:  if (cnt == CNT_W'(1)) state_nxt = DONE;
        DIV:  if (cnt == CNT_W'(1)) state_nxt = DONE;
        DONE: state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      md_result <= '0;
      f3_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      bmag_q    <= '0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
    end else if (flush) begin
      cnt <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          f3_q   <= funct3[1:0];
          a_q    <= srcA;
          b_q    <= srcB;
          rem_q  <= '0;
          quo_q  <= a_mag;
          bmag_q <= b_mag;
          q_neg  <= a_neg ^ b_neg;
          r_neg  <= a_neg;
          if (!funct3[2]) cnt <= CNT_W'(MUL_CYCLES);
          else if (div_special) begin
            cnt       <= '0;
            md_result <= special_res;
          end else cnt <= CNT_W'(W);
        end
        MUL: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) md_result <= mul_res;
        end
        DIV: begin
          cnt   <= cnt - CNT_W'(1);
          rem_q <= rem_nxt;
          quo_q <= quo_nxt;
          if (cnt == CNT_W'(1)) md_result <= div_res;
        end
        default: cnt <= '0;
      endcase
    end
  end

  always_comb begin
    md_valid = !rst && (state == DONE);
    stall    = !rst && (((state == IDLE) && start) || (state == MUL) || (state == DIV));
  end

  always_comb begin
    alu_ctrl = ALU_ADD;
    case (ALUOp)
      ALU_OP_WIDTH'(0): alu_ctrl = ALU_ADD;
      ALU_OP_WIDTH'(1): alu_ctrl = ALU_SUB;
      ALU_OP_WIDTH'(3): alu_ctrl = ALU_PASSB;
      ALU_OP_WIDTH'(2): begin
        if (m_op) alu_ctrl = ALU_ADD;
        else begin
          case (funct3[2:0])
            3'b000: alu_ctrl = (op[5] && funct7_5) ? ALU_SUB : ALU_ADD;
            3'b001: alu_ctrl = ALU_SLL;
            3'b010: alu_ctrl = ALU_SLT;
            3'b011: alu_ctrl = ALU_SLTU;
            3'b100: alu_ctrl = ALU_XOR;
            3'b101: alu_ctrl = funct7_5 ? ALU_SRA : ALU_SRL;
            3'b110: alu_ctrl = ALU_OR;
            default: alu_ctrl = ALU_AND;
          endcase
        end
      end
      default: alu_ctrl = ALU_ADD;
    endcase
    ALUControl = ALU_CTRL_WIDTH'(alu_ctrl);
  end
endmodule

// File: tb/tb_alu_decoder_ext.sv
// Bench for alu_decoder_ext: directed and randomized decode and mul/div checks
// against a behavioural model of the RV32IM rules.
module tb_alu_decoder_ext;
  logic        clk = 1'b0;
  logic        rst, valid, flush, funct7_5, funct7_0;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic [1:0]  ALUOp;
  logic [31:0] srcA, srcB;
  logic [3:0]  ALUControl;
  logic        stall, md_valid;
  logic [31:0] md_result;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_decoder_ext #(
    .OP_WIDTH(7), .FUNCT3_WIDTH(3), .ALU_OP_WIDTH(2),
    .ALU_CTRL_WIDTH(4), .DATA_WIDTH(32), .MUL_CYCLES(2)
  ) dut (
    .clk(clk), .rst(rst), .valid(valid), .flush(flush), .op(op),
    .funct3(funct3), .funct7_5(funct7_5), .funct7_0(funct7_0), .ALUOp(ALUOp),
    .srcA(srcA), .srcB(srcB), .ALUControl(ALUControl), .stall(stall),
    .md_valid(md_valid), .md_result(md_result)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] ref_alu(input logic [1:0] aop, input logic op5,
                                         input logic f75, input logic f70, input logic [2:0] f3);
    logic [3:0] tbl [8];
    tbl = '{4'd0, 4'd7, 4'd5, 4'd6, 4'd4, 4'd8, 4'd3, 4'd2};
    if (aop == 2'd1) return 4'd1;
    if (aop == 2'd3) return 4'd10;
    if (aop != 2'd2 || (op5 && f70)) return 4'd0;
    if (f3 == 3'd0 && op5 && f75) return 4'd1;
    if (f3 == 3'd5 && f75) return 4'd9;
    return tbl[f3];
  endfunction

  function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    int ia, ib;
    sa = longint'(signed'(a)); sb = longint'(signed'(b));
    ua = longint'({32'h0, a});  ub = longint'({32'h0, b});
    ia = signed'(a); ib = signed'(b);
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h8000_0000 : 32'(ia / ib);
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h0 : 32'(ia % ib);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (!f3[2]) return 3;
    if (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
    return 33;
  endfunction

  task automatic apply_mop(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    op = 7'b0110011; ALUOp = 2'd2; funct7_0 = 1'b1; funct7_5 = 1'b0;
    funct3 = f3; srcA = a; srcB = b; valid = 1'b1;
  endtask

  // Called at posedge+1; returns at posedge+2 of the IDLE cycle after DONE.
  task automatic run_mop(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat);
    int stalls = 0;
    logic got = 1'b0;
    apply_mop(f3, a, b);
    #1 check({tag, "_aluctrl"}, 32'(ALUControl), 32'd0);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (md_valid) begin got = 1'b1; break; end
      if (stall) stalls++;
      @(posedge clk); #1;
    end
    check({tag, "_done"}, 32'(got), 32'd1);
    check({tag, "_stalls"}, 32'(stalls), 32'(lat));
    check({tag, "_stall_done"}, 32'(stall), 32'd0);
    check({tag, "_result"}, md_result, exp);
    @(posedge clk); #1;
    valid = 1'b0;
    #1;
    check({tag, "_valid_after"}, 32'(md_valid), 32'd0);
    check({tag, "_hold"}, md_result, exp);
  endtask

  initial begin
    logic [31:0] a, b, prior;
    logic [2:0]  f3;
    int          pulses;

    rst = 1'b1; valid = 1'b0; flush = 1'b0; op = 7'b0110011; funct3 = 3'd0;
    funct7_5 = 1'b0; funct7_0 = 1'b0; ALUOp = 2'd0; srcA = '0; srcB = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_md_valid", 32'(md_valid), 32'd0);
    check("rst_md_result", md_result, 32'd0);
    rst = 1'b0;

    ALUOp = 2'd2; op = 7'b0110011; funct7_5 = 1'b1; funct7_0 = 1'b0; funct3 = 3'd0;
    #1 check("dec_sub", 32'(ALUControl), 32'd1);
    op = 7'b0010011;
    #1 check("dec_addi", 32'(ALUControl), 32'd0);
    funct3 = 3'd5;
    #1 check("dec_srai", 32'(ALUControl), 32'd9);
    funct3 = 3'd7;
    #1 check("dec_and", 32'(ALUControl), 32'd2);
    ALUOp = 2'd3;
    #1 check("dec_passb", 32'(ALUControl), 32'd10);
    ALUOp = 2'd1;
    #1 check("dec_branch", 32'(ALUControl), 32'd1);
    for (int i = 0; i < 40; i++) begin
      ALUOp = 2'($urandom_range(0, 3)); op = 7'($urandom); funct3 = 3'($urandom);
      funct7_5 = 1'($urandom); funct7_0 = 1'($urandom);
      #1 check("dec_rand", 32'(ALUControl), 32'(ref_alu(ALUOp, op[5], funct7_5, funct7_0, funct3)));
    end
    ALUOp = 2'd0;
    @(posedge clk); #1;

    run_mop("mul", 3'd0, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 3);
    run_mop("mulh", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 3);
    run_mop("div", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run_mop("rem", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    run_mop("divu_zero", 3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run_mop("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
    run_mop("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);

    for (int i = 0; i < 25; i++) begin
      f3 = 3'($urandom);
      a = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin b = 32'hFFFF_FFFF; if ($urandom_range(0, 1) == 1) a = 32'h8000_0000; end
        2: b = 32'($urandom_range(1, 16));
        default: b = $urandom;
      endcase
      run_mop("rand_md", f3, a, b, ref_md(f3, a, b), ref_lat(f3, a, b));
    end

    prior = md_result;
    apply_mop(3'd4, 32'd100, 32'd7);
    repeat (10) begin @(posedge clk); #1; end
    flush = 1'b1; valid = 1'b0;
    @(posedge clk); #1;
    flush = 1'b0;
    #1;
    check("flush_stall", 32'(stall), 32'd0);
    check("flush_md_valid", 32'(md_valid), 32'd0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (md_valid) pulses++;
    end
    check("flush_no_pulse", 32'(pulses), 32'd0);
    check("flush_hold", md_result, prior);

    @(posedge clk); #1;
    apply_mop(3'd0, 32'd3, 32'd5);
    @(posedge clk); #1;
    rst = 1'b1; valid = 1'b0;
    #1 check("rst_mid_stall_comb", 32'(stall), 32'd0);
    @(posedge clk); #1;
    check("rst_mid_stall", 32'(stall), 32'd0);
    check("rst_mid_md_valid", 32'(md_valid), 32'd0);
    check("rst_mid_md_result", md_result, 32'd0);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (md_valid) pulses++;
    end
    check("rst_mid_no_pulse", 32'(pulses), 32'd0);
    @(posedge clk); #1;
    run_mop("mul_after_rst", 3'd0, 32'd6, 32'd7, 32'd42, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
